// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
package ctrl_pkg;

  localparam int unsigned OPC_W  = 7;
  localparam int unsigned ALUOP_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_I    = 3'd1,
    CLS_LD   = 3'd2,
    CLS_SD   = 3'd3,
    CLS_BEQ  = 3'd4,
    CLS_HALT = 3'd5,
    CLS_BAD  = 3'd6
  } inst_class_t;

  localparam logic [OPC_W-1:0] OPC_R    = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_I    = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_SD   = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BEQ  = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_HALT = 7'b1110011;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 2'b00;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 2'b01;
  localparam logic [ALUOP_W-1:0] ALU_AND = 2'b10;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 2'b11;

endpackage

// File: rtl/inst_decoder.sv
// Combinational decode of the latched instruction word.
module inst_decoder
  import ctrl_pkg::*;
#(
  parameter int unsigned BITS = 64
) (
  input  logic [31:0]        ir,
  output inst_class_t        cls,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               alu_src,
  output logic [BITS-1:0]    imm,
  output logic               illegal
);

  logic [OPC_W-1:0] opcode;
  logic [2:0]       funct3;
  logic             funct7_5;
  logic [11:0]      imm_i;
  logic [11:0]      imm_s;
  logic [11:0]      imm_b;
  logic [4:0]       rs1_unused;

  assign opcode     = ir[6:0];
  assign funct3     = ir[14:12];
  assign funct7_5   = ir[30];
  assign imm_i      = ir[31:20];
  assign imm_s      = {ir[31:25], ir[11:7]};
  assign imm_b      = {ir[31], ir[7], ir[30:25], ir[11:8]};
  assign rs1_unused = ir[19:15];

  // Class, ALU op, operand select, immediate and legality from opcode/funct fields
  always_comb begin
    cls     = CLS_BAD;
    alu_op  = ALU_ADD;
    alu_src = 1'b0;
    imm     = '0;
    illegal = 1'b0;
    case (opcode)
      OPC_R: begin
        cls = CLS_R;
        case (funct3)
          3'b000:  alu_op = funct7_5 ? ALU_SUB : ALU_ADD;
          3'b111:  alu_op = ALU_AND;
          3'b110:  alu_op = ALU_OR;
          default: illegal = 1'b1;
        endcase
      end
      OPC_I: begin
        cls     = CLS_I;
        alu_src = 1'b1;
        imm     = {{(BITS-12){imm_i[11]}}, imm_i};
        case (funct3)
          3'b000:  alu_op = ALU_ADD;
          3'b111:  alu_op = ALU_AND;
          3'b110:  alu_op = ALU_OR;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LD: begin
        cls     = CLS_LD;
        alu_src = 1'b1;
        imm     = {{(BITS-12){imm_i[11]}}, imm_i};
        illegal = (funct3 != 3'b011);
      end
      OPC_SD: begin
        cls     = CLS_SD;
        alu_src = 1'b1;
        imm     = {{(BITS-12){imm_s[11]}}, imm_s};
        illegal = (funct3 != 3'b011);
      end
      OPC_BEQ: begin
        cls     = CLS_BEQ;
        alu_op  = ALU_SUB;
        imm     = {{(BITS-12){imm_b[11]}}, imm_b};
        illegal = (funct3 != 3'b000);
      end
      OPC_HALT: cls = CLS_HALT;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer driving the scalar datapath control strobes.
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned BITS  = 64,
  parameter int unsigned CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [31:0]         Instruction,
  input  logic [3:0]          ALUFlags,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic [ALUOP_W-1:0]  ALUControl,
  output logic                RegWrite,
  output logic                MemWrite,
  output logic                mem_req,
  output logic                Branch,
  output logic                MemToReg,
  output logic                ALUScr,
  output logic [BITS-1:0]     Imm,
  output logic                halted,
  output logic                illegal,
  output logic [CNT_W-1:0]    retired
);

  state_t               state;
  state_t               state_next;
  logic [31:0]          ir;
  logic                 retire;
  inst_class_t          cls;
  logic [ALUOP_W-1:0]   dec_alu_op;
  logic                 dec_alu_src;
  logic                 dec_illegal;
  logic                 flags_unused;

  // Branch resolution happens in the datapath, so flags are not consumed here
  assign flags_unused = ^ALUFlags;

  inst_decoder #(.BITS(BITS)) u_dec (
    .ir      (ir),
    .cls     (cls),
    .alu_op  (dec_alu_op),
    .alu_src (dec_alu_src),
    .imm     (Imm),
    .illegal (dec_illegal)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Instruction register, retired counter and sticky illegal flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir      <= '0;
      retired <= '0;
      illegal <= 1'b0;
    end else begin
      if (state == ST_FETCH) ir <= Instruction;
      if (retire) retired <= retired + CNT_W'(1);
      if (state == ST_DECODE && dec_illegal) illegal <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_FETCH;
      ST_FETCH:  state_next = ST_DECODE;
      ST_DECODE: begin
        if (dec_illegal || cls == CLS_HALT) state_next = ST_HALT;
        else                                 state_next = ST_EXEC;
      end
      ST_EXEC: begin
        case (cls)
          CLS_LD, CLS_SD: state_next = ST_MEM;
          CLS_BEQ:        state_next = ST_FETCH;
          default:        state_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) state_next = (cls == CLS_SD) ? ST_FETCH : ST_WB;
      end
      ST_WB:   state_next = ST_FETCH;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_IDLE;
    endcase
  end

  // Control strobes from registered state and IR
  always_comb begin
    PCWrite    = 1'b0;
    ALUControl = ALU_ADD;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    mem_req    = 1'b0;
    Branch     = 1'b0;
    MemToReg   = 1'b0;
    ALUScr     = 1'b0;
    retire     = 1'b0;
    halted     = (state == ST_HALT);
    case (state)
      ST_EXEC: begin
        ALUControl = dec_alu_op;
        ALUScr     = dec_alu_src;
        if (cls == CLS_BEQ) begin
          Branch  = 1'b1;
          PCWrite = 1'b1;
          retire  = 1'b1;
        end
      end
      ST_MEM: begin
        ALUControl = ALU_ADD;
        ALUScr     = 1'b1;
        mem_req    = 1'b1;
        MemWrite   = (cls == CLS_SD);
        if (mem_ready && cls == CLS_SD) begin
          PCWrite = 1'b1;
          retire  = 1'b1;
        end
      end
      ST_WB: begin
        ALUControl = dec_alu_op;
        ALUScr     = dec_alu_src;
        RegWrite   = 1'b1;
        MemToReg   = (cls == CLS_LD);
        PCWrite    = 1'b1;
        retire     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit.
module tb_multicycle_control_unit;

  localparam int unsigned BITS  = 64;
  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [31:0]      Instruction;
  logic [3:0]       ALUFlags;
  logic             mem_ready;
  logic             PCWrite;
  logic [1:0]       ALUControl;
  logic             RegWrite;
  logic             MemWrite;
  logic             mem_req;
  logic             Branch;
  logic             MemToReg;
  logic             ALUScr;
  logic [BITS-1:0]  Imm;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_control_unit #(.BITS(BITS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .Instruction(Instruction),
    .ALUFlags(ALUFlags), .mem_ready(mem_ready), .PCWrite(PCWrite),
    .ALUControl(ALUControl), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .mem_req(mem_req), .Branch(Branch), .MemToReg(MemToReg), .ALUScr(ALUScr),
    .Imm(Imm), .halted(halted), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // All write/request strobes together
  function automatic logic [4:0] strobes();
    return {PCWrite, RegWrite, MemWrite, mem_req, Branch};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; Instruction = 32'h0; ALUFlags = 4'h0; mem_ready = 1'b0;
    #12;
    check("rst_strobes", 64'(strobes()), 64'h0);
    check("rst_imm", Imm, 64'h0);
    check("rst_retired", 64'(retired), 64'h0);
    check("rst_halted", 64'({halted, illegal}), 64'h0);
    tick();
    rst = 1'b0;

    // add x3,x1,x2
    start = 1'b1;
    tick();                                  // FETCH
    start = 1'b0;
    Instruction = 32'h002081B3;
    check("add_fetch_strb", 64'(strobes()), 64'h0);
    tick();                                  // DECODE
    check("add_dec_strb", 64'(strobes()), 64'h0);
    tick();                                  // EXEC
    check("add_exec_strb", 64'(strobes()), 64'h0);
    tick();                                  // WB
    check("add_wb_regwr", 64'(RegWrite), 64'h1);
    check("add_wb_aluctl", 64'(ALUControl), 64'h0);
    check("add_wb_aluscr", 64'(ALUScr), 64'h0);
    check("add_wb_pcwr", 64'(PCWrite), 64'h1);
    check("add_wb_memtoreg", 64'(MemToReg), 64'h0);
    Instruction = 32'hFFF00093;              // addi x1,x0,-1
    tick();                                  // FETCH
    check("add_retired", 64'(retired), 64'h1);
    check("addi_fetch_pcwr", 64'(PCWrite), 64'h0);
    tick();                                  // DECODE
    tick();                                  // EXEC
    check("addi_exec_imm", Imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addi_exec_aluscr", 64'(ALUScr), 64'h1);
    check("addi_exec_regwr", 64'(RegWrite), 64'h0);
    tick();                                  // WB
    check("addi_wb_regwr", 64'(RegWrite), 64'h1);
    check("addi_wb_aluscr", 64'(ALUScr), 64'h1);
    Instruction = 32'h0020B423;              // sd x2,8(x1)
    tick();                                  // FETCH
    check("addi_retired", 64'(retired), 64'h2);
    tick();                                  // DECODE
    tick();                                  // EXEC
    check("sd_exec_memreq", 64'(mem_req), 64'h0);
    check("sd_imm", Imm, 64'h8);
    tick();                                  // MEM, waiting
    for (int i = 0; i < 3; i++) begin
      check("sd_wait_strb", 64'(strobes()), 64'b00110);
      check("sd_wait_aluscr", 64'(ALUScr), 64'h1);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("sd_ready_strb", 64'(strobes()), 64'b10110);
    Instruction = 32'hFE000EE3;              // beq x0,x0,-4
    tick();                                  // FETCH
    mem_ready = 1'b1;                        // ignored outside MEM
    check("sd_retired", 64'(retired), 64'h3);
    check("sd_after_strb", 64'(strobes()), 64'h0);
    tick();                                  // DECODE
    mem_ready = 1'b0;
    tick();                                  // EXEC
    check("beq_imm", Imm, 64'hFFFF_FFFF_FFFF_FFFE);
    check("beq_strb", 64'(strobes()), 64'b10001);
    check("beq_aluctl", 64'(ALUControl), 64'h1);
    Instruction = 32'h00000073;              // halt
    tick();                                  // FETCH
    check("beq_retired", 64'(retired), 64'h4);
    check("beq_next_strb", 64'(strobes()), 64'h0);
    tick();                                  // DECODE
    tick();                                  // HALT
    check("halt_flags", 64'({halted, illegal}), 64'b10);
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    check("halt_sticky", 64'({halted, illegal}), 64'b10);
    check("halt_strb", 64'(strobes()), 64'h0);
    check("halt_retired", 64'(retired), 64'h4);

    // undecodable opcode
    do_reset();
    check("rst2_flags", 64'({halted, illegal, retired}), 64'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    Instruction = 32'h0000007F;
    tick();
    tick();
    check("illegal_flags", 64'({halted, illegal}), 64'b11);
    check("illegal_strb", 64'(strobes()), 64'h0);

    // reset during a stalled load
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    Instruction = 32'h00013083;              // ld x1,0(x2)
    tick();
    tick();
    tick();                                  // MEM
    check("ld_mem_strb", 64'(strobes()), 64'b00010);
    tick();
    check("ld_stall_strb", 64'(strobes()), 64'b00010);
    rst = 1'b1;
    #1;
    check("ld_rst_memreq", 64'(mem_req), 64'h0);
    check("ld_rst_retired", 64'(retired), 64'h0);
    tick();
    mem_ready = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ld_post_rst_strb", 64'({strobes(), MemToReg}), 64'h0);
    end
    check("ld_post_rst_retired", 64'(retired), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Multi-cycle sequencer for the 64-bit scalar datapath (PC, instruction memory, register file, 4-op ALU, data memory, write-back mux).
- Latches each fetched 32-bit RISC-V-encoded instruction and steps it through FETCH/DECODE/EXEC/MEM/WB.
- Drives the datapath control strobes and the sign-extended immediate, with a ready handshake toward data memory.
- Sits beside the datapath in the top level, replacing single-cycle combinational control.

Parameters:
BITS, 64, datapath width and immediate output width
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  leaves IDLE and begins fetching
Instruction  input  32  instruction word from instruction memory
ALUFlags  input  4  ALU flags; bit0 = zero
mem_ready  input  1  data memory completed current access
PCWrite  output  1  PC update enable
ALUControl  output  2  00 add, 01 sub, 10 and, 11 or
RegWrite  output  1  register file write enable
MemWrite  output  1  data memory write enable
mem_req  output  1  data memory access request
Branch  output  1  branch qualifier (datapath ANDs with zero flag)
MemToReg  output  1  write-back select memory
ALUScr  output  1  ALU B operand = Imm
Imm  output  BITS  sign-extended immediate
halted  output  1  HALT reached
illegal  output  1  HALT caused by undecodable opcode
retired  output  CNT_W  retired-instruction count

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; IR, retired, halted and illegal are cleared.
  - All strobes are 0 and Imm is 0.
  - Reset mid-operation aborts the instruction; no write strobe is asserted after rst rises.
- Control outputs are decoded combinationally from the registered state and registered IR only, never from live Instruction.
- States and transitions:
  - IDLE: start=1 -> FETCH.
  - FETCH: IR <= Instruction at cycle end -> DECODE.
  - DECODE: opcode 0110011 (R), 0010011 (I-ALU), 0000011 (ld), 0100011 (sd), 1100011 (beq) -> EXEC. Opcode 1110011 -> HALT. Any other opcode -> HALT with illegal=1.
  - EXEC:
    - R/I -> WB.
    - ld/sd -> MEM.
    - beq: Branch=1, PCWrite=1, ALUControl=sub -> FETCH; retired increments.
  - MEM:
    - ALUControl=add, ALUScr=1, mem_req=1, and MemWrite=1 for sd.
    - Hold all of these until mem_ready=1.
    - On ready, ld -> WB. On ready, sd asserts PCWrite=1 that cycle -> FETCH; retired increments.
  - WB: RegWrite=1, MemToReg=1 for ld; ALU op held stable; PCWrite=1 -> FETCH; retired increments.
  - HALT: halted=1, all strobes 0. Sticky until rst; start is ignored.
- ALU op selection:
  - R-type: funct3 000 with funct7[5]=0 -> add; funct3 000 with funct7[5]=1 -> sub; 111 -> and; 110 -> or. Other funct3 -> illegal.
  - I-ALU: funct3 000 -> add; 111 -> and; 110 -> or; other -> illegal.
  - ld/sd: require funct3 011. beq: require funct3 000. Mismatch -> illegal.
  - ALUScr=1 for I-ALU, ld and sd.
- Immediates:
  - I-type: sext(IR[31:20]).
  - S-type: sext({IR[31:25], IR[11:7]}).
  - B-type: sext({IR[31], IR[7], IR[30:25], IR[11:8]}), in halfword units; the datapath shifts it.
  - R-type: 0.
- Latency: R/I 4 cycles; beq 3; ld 5+wait; sd 4+wait.
- retired wraps modulo 2^CNT_W.
- mem_ready outside MEM is ignored.

Decomposition:
- Package ctrl_pkg:
  - state enum (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT);
  - opcode constants;
  - ALU op constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR);
  - instruction class enum.
- Sub-module inst_decoder: combinational, IR -> class, ALU op, ALUScr, Imm, illegal.
- The top module holds the FSM, IR and retired counter.

Test Plan:
- Reset, pulse start, feed 0x002081B3 (add x3,x1,x2) -> FETCH, DECODE, EXEC, WB. In WB: RegWrite=1, ALUControl=00, ALUScr=0. PCWrite=1 in WB only; retired=1.
- 0xFFF00093 (addi x1,x0,-1) -> Imm=0xFFFFFFFFFFFFFFFF, ALUScr=1 in EXEC/WB, RegWrite only in WB.
- 0x0020B423 (sd x2,8(x1)), mem_ready low for 3 MEM cycles -> Imm=8; mem_req=1 and MemWrite=1 held 4 cycles; PCWrite on ready cycle; RegWrite never 1.
- 0xFE000EE3 (beq x0,x0,-4) -> Imm=0xFFFFFFFFFFFFFFFE, Branch=1, ALUControl=01, PCWrite=1 in EXEC; next state FETCH.
- 0x00000073 -> halted=1, illegal=0, strobes 0, start ignored. Separately 0x0000007F -> halted=1, illegal=1.
- Assert rst during MEM of a load with mem_ready low -> state IDLE, mem_req=0, retired=0, no RegWrite afterwards.
